pc_w_mux: RTL and testbench



---
 rtl/pc_w_mux_if.sv | 31 +++
 rtl/pc_w_mux.sv | 60 ++++++
 tb/tb_pc_w_mux.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pc_w_mux_if.sv
// Control/data bundle between the control unit, decoder, stack path and the
// program counter. The master side drives next-address controls and sources;
// the slave side (the program counter) returns the registered PC_COUNT.
interface pc_w_mux_if;

    logic       LD;          // load enable, takes the SEL-selected source
    logic       INC;         // increment enable, ignored while LD=1
    logic [1:0] SEL;         // next-address source select
    logic [9:0] FROM_IMMED;  // branch/call target from the instruction word
    logic [9:0] FROM_STACK;  // return address popped from the stack
    logic [9:0] PC_COUNT;    // registered program counter

    modport master (
        output LD,
        output INC,
        output SEL,
        output FROM_IMMED,
        output FROM_STACK,
        input  PC_COUNT
    );

    modport slave (
        input  LD,
        input  INC,
        input  SEL,
        input  FROM_IMMED,
        input  FROM_STACK,
        output PC_COUNT
    );

endinterface

// File: rtl/pc_w_mux.sv
// Program counter for the RAT CPU with its next-address multiplexer.
// Each rising CLK either resets, loads from the selected source, increments
// (modulo 1024) or holds. PC_COUNT is driven directly by the register.
module pc_w_mux (
    input  logic        CLK,
    input  logic        RST,
    pc_w_mux_if.slave   bus
);

    typedef enum logic [1:0] {
        SEL_IMMED  = 2'd0,
        SEL_STACK  = 2'd1,
        SEL_VECTOR = 2'd2,
        SEL_ZERO   = 2'd3
    } sel_e;

    localparam logic [9:0] INT_VECTOR = 10'h3FF;

    sel_e       sel;
    logic [9:0] mux_d;
    logic [9:0] pc_d;
    // Power-up value so PC_COUNT is defined before the first reset.
    logic [9:0] pc_q = '0;

    assign sel = sel_e'(bus.SEL);

    // Next-address source selection.
    always_comb begin
        mux_d = '0;
        unique case (sel)
            SEL_IMMED:  mux_d = bus.FROM_IMMED;
            SEL_STACK:  mux_d = bus.FROM_STACK;
            SEL_VECTOR: mux_d = INT_VECTOR;
            SEL_ZERO:   mux_d = '0;
            default:    mux_d = '0;
        endcase
    end

    // Update priority below reset: load beats increment beats hold.
    always_comb begin
        pc_d = pc_q;
        if (bus.LD) begin
            pc_d = mux_d;
        end else if (bus.INC) begin
            pc_d = pc_q + 10'd1;
        end
    end

    // Program counter register with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.PC_COUNT = pc_q;

endmodule

// File: tb/tb_pc_w_mux.sv
// Directed self-checking bench for pc_w_mux.
module tb_pc_w_mux;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pc_w_mux_if bus ();

    pc_w_mux dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [9:0] expected);
        checks++;
        assert (bus.PC_COUNT === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, bus.PC_COUNT, expected);
        end
    endtask

    // Drive inputs at the falling edge, clock once, check 1 ns after the rise.
    task automatic step(input logic rst, input logic ld, input logic inc,
                        input logic [1:0] sel, input logic [9:0] imm,
                        input logic [9:0] stk, input string tag,
                        input logic [9:0] expected);
        @(negedge CLK);
        RST            = rst;
        bus.LD         = ld;
        bus.INC        = inc;
        bus.SEL        = sel;
        bus.FROM_IMMED = imm;
        bus.FROM_STACK = stk;
        @(posedge CLK);
        #1;
        check(tag, expected);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.LD         = 1'b0;
        bus.INC        = 1'b0;
        bus.SEL        = 2'd0;
        bus.FROM_IMMED = '0;
        bus.FROM_STACK = '0;

        // Power-up value before any reset.
        #1;
        check("powerup", 10'h000);

        // Reset beats load from a non-zero state.
        step(1'b0, 1'b1, 1'b0, 2'd0, 10'h155, 10'h000, "load_155", 10'h155);
        step(1'b1, 1'b1, 1'b0, 2'd0, 10'h004, 10'h000, "rst_beats_ld", 10'h000);

        // Increment three times, then hold twice.
        step(1'b0, 1'b0, 1'b1, 2'd0, 10'h000, 10'h000, "inc1", 10'h001);
        step(1'b0, 1'b0, 1'b1, 2'd0, 10'h000, 10'h000, "inc2", 10'h002);
        step(1'b0, 1'b0, 1'b1, 2'd0, 10'h000, 10'h000, "inc3", 10'h003);
        step(1'b0, 1'b0, 1'b0, 2'd0, 10'h000, 10'h000, "hold1", 10'h003);
        step(1'b0, 1'b0, 1'b0, 2'd0, 10'h000, 10'h000, "hold2", 10'h003);

        // Mux decode across all selects.
        step(1'b0, 1'b1, 1'b0, 2'd0, 10'h004, 10'h005, "sel0_immed", 10'h004);
        step(1'b0, 1'b1, 1'b0, 2'd1, 10'h004, 10'h005, "sel1_stack", 10'h005);
        step(1'b0, 1'b1, 1'b0, 2'd2, 10'h004, 10'h005, "sel2_vector", 10'h3FF);
        step(1'b0, 1'b1, 1'b0, 2'd3, 10'h004, 10'h005, "sel3_zero", 10'h000);
        step(1'b0, 1'b1, 1'b0, 2'd2, 10'h004, 10'h005, "sel2_again", 10'h3FF);

        // Wrap from 0x3FF.
        step(1'b0, 1'b0, 1'b1, 2'd2, 10'h004, 10'h005, "wrap_to_0", 10'h000);
        step(1'b0, 1'b0, 1'b1, 2'd2, 10'h004, 10'h005, "wrap_then_1", 10'h001);

        // Load wins over increment.
        step(1'b0, 1'b1, 1'b1, 2'd1, 10'h000, 10'h2A0, "ld_beats_inc", 10'h2A0);

        // Data and select ignored while LD=0, INC=0.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 2'($urandom_range(3)), 10'($urandom),
                 10'($urandom), $sformatf("hold_rand%0d", i), 10'h2A0);
        end

        // Same-cycle ignore: LD=0 INC=1 with arbitrary sources increments.
        step(1'b0, 1'b0, 1'b1, 2'd0, 10'h123, 10'h321, "inc_ignores_src", 10'h2A1);

        // Mid-sequence reset with INC=1, then first post-reset increment.
        step(1'b1, 1'b0, 1'b1, 2'd0, 10'h000, 10'h000, "rst_beats_inc", 10'h000);
        step(1'b0, 1'b0, 1'b1, 2'd0, 10'h000, 10'h000, "post_rst_inc", 10'h001);

        // No combinational path: change inputs with no edge in between.
        bus.LD         = 1'b1;
        bus.INC        = 1'b1;
        bus.SEL        = 2'd0;
        bus.FROM_IMMED = 10'h1F0;
        #2;
        check("no_comb_path", 10'h001);

        // Glitch between edges that is gone before the edge has no effect.
        @(negedge CLK);
        bus.LD         = 1'b1;
        bus.INC        = 1'b0;
        bus.FROM_IMMED = 10'h111;
        #2;
        bus.LD         = 1'b0;
        @(posedge CLK);
        #1;
        check("between_edge_glitch", 10'h001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
